// File: rtl/sub_bytes_seq.sv
// sub_bytes_seq: sequential AES SubBytes engine.
// Accepts a 128-bit state on a valid/ready handshake, substitutes LANES bytes
// per clock in place through LANES S-box lookups, then presents the result on
// a second valid/ready handshake. Byte i of a state lives at bits [8i:8i+7].
// Optional feature macro: SUB_BYTES_INV_EN adds an `inv` port that selects the
// inverse S-box for the whole block (sampled when the block is accepted).
module sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] state_in,
  output logic         out_valid,
  input  logic         out_ready,
`ifdef SUB_BYTES_INV_EN
  input  logic         inv,
`endif
  output logic [0:127] state_out,
  output logic         busy
);

  localparam int GROUPS = 16 / LANES;
  localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GROUPS - 1);

  // Forward S-box, byte b at bits [8b:8b+7].
  localparam logic [0:2047] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

`ifdef SUB_BYTES_INV_EN
  // Inverse S-box, same layout as the forward table.
  localparam logic [0:2047] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic mode);
    return mode ? SBOX_INV[{b, 3'b000} +: 8] : SBOX_FWD[{b, 3'b000} +: 8];
  endfunction
`else
  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX_FWD[{b, 3'b000} +: 8];
  endfunction
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [0:127]     work_q, work_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic [3:0]       byte_idx;
`ifdef SUB_BYTES_INV_EN
  logic             inv_q, inv_d;
`endif

  // Next-state, group counter, in-place substitution and registered outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    byte_idx    = '0;
`ifdef SUB_BYTES_INV_EN
    inv_d       = inv_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          work_d     = state_in;
          cnt_d      = '0;
          state_d    = RUN;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
`ifdef SUB_BYTES_INV_EN
          inv_d      = inv;
`endif
        end
      end
      RUN: begin
        // Only the current group of LANES bytes changes; the rest hold.
        for (int l = 0; l < LANES; l++) begin
          byte_idx = 4'(int'(cnt_q) * LANES + l);
`ifdef SUB_BYTES_INV_EN
          work_d[{byte_idx, 3'b000} +: 8] = sub_byte(work_q[{byte_idx, 3'b000} +: 8], inv_q);
`else
          work_d[{byte_idx, 3'b000} +: 8] = sub_byte(work_q[{byte_idx, 3'b000} +: 8]);
`endif
        end
        // Leaving on the terminal value keeps cnt from ever wrapping.
        if (cnt_q == CNT_LAST) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // State register; reset aborts any block in flight and clears the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SUB_BYTES_INV_EN
      inv_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef SUB_BYTES_INV_EN
      inv_q       <= inv_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign state_out = work_q;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// tb_sub_bytes_seq: directed bench for sub_bytes_seq. Five instances cover
// LANES = 1, 2, 4, 8, 16 (instance g has LANES = 1 << g); most scenarios use
// the LANES=4 instance. Expected values are hand-computed from the AES S-box.
module tb_sub_bytes_seq;

  localparam logic [127:0] ZERO   = 128'h0;
  localparam logic [127:0] ALL63  = 128'h63636363636363636363636363636363;
  localparam logic [127:0] ALL53  = 128'h53535353535353535353535353535353;
  localparam logic [127:0] ALLED  = 128'hedededededededededededededededed;
  localparam logic [127:0] KV_IN  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KV_OUT = 128'h638293c31bfc33f5c4eeacea4bc12816;

  logic         clk;
  logic         rst;
  logic [0:127] st_in;
  logic [4:0]   in_valid;
  logic [4:0]   out_ready;
  logic [4:0]   in_ready_w;
  logic [4:0]   out_valid_w;
  logic [4:0]   busy_w;
  logic [0:127] st_out_w [5];
`ifdef SUB_BYTES_INV_EN
  logic         inv_r;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    sub_bytes_seq #(.LANES(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready_w[g]),
      .state_in  (st_in),
      .out_valid (out_valid_w[g]),
      .out_ready (out_ready[g]),
`ifdef SUB_BYTES_INV_EN
      .inv       (inv_r),
`endif
      .state_out (st_out_w[g]),
      .busy      (busy_w[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Present one block to instance g and wait (bounded) for out_valid.
  task automatic start_and_wait(input int g, input logic [127:0] din, output int lat);
    @(negedge clk);
    chk($sformatf("in_ready_idle[%0d]", g), 128'(in_ready_w[g]), 128'(1));
    st_in       = din;
    in_valid[g] = 1'b1;
    @(posedge clk); #1;
    in_valid[g] = 1'b0;
    chk($sformatf("busy_run[%0d]", g), 128'(busy_w[g]), 128'(1));
    lat = 0;
    while (out_valid_w[g] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Full block: latency, result, then handshake back to IDLE.
  task automatic run_block(input int g, input logic [127:0] din,
                           input logic [127:0] exp, input int exp_lat);
    int lat;
    start_and_wait(g, din, lat);
    chk($sformatf("latency[%0d]", g), 128'(lat), 128'(exp_lat));
    chk($sformatf("result[%0d]", g), 128'(st_out_w[g]), exp);
    @(negedge clk);
    out_ready[g] = 1'b1;
    @(posedge clk); #1;
    out_ready[g] = 1'b0;
    chk($sformatf("idle_in_ready[%0d]", g), 128'(in_ready_w[g]), 128'(1));
    chk($sformatf("idle_out_valid[%0d]", g), 128'(out_valid_w[g]), 128'(0));
  endtask

  initial begin
    int lat;
    int ov_seen;
    rst       = 1'b1;
    st_in     = '0;
    in_valid  = '0;
    out_ready = '0;
`ifdef SUB_BYTES_INV_EN
    inv_r     = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset values.
    chk("rst_in_ready", 128'(in_ready_w[2]), 128'(1));
    chk("rst_out_valid", 128'(out_valid_w[2]), 128'(0));
    chk("rst_busy", 128'(busy_w[2]), 128'(0));
    chk("rst_state_out", 128'(st_out_w[2]), ZERO);

    // All-zero input, then the known vector with byte-order spot checks.
    run_block(2, ZERO, ALL63, 4);
    run_block(2, KV_IN, KV_OUT, 4);
    chk("byte0_bits0_7", 128'(st_out_w[2][0:7]), 128'h63);
    chk("byte15_bits120_127", 128'(st_out_w[2][120:127]), 128'h16);

    // Backpressure: hold DONE for 10 cycles while a stray in_valid is offered.
    start_and_wait(2, KV_IN, lat);
    chk("bp_latency", 128'(lat), 128'(4));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      st_in       = ALL53;
      in_valid[2] = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("bp_out_valid[%0d]", i), 128'(out_valid_w[2]), 128'(1));
      chk($sformatf("bp_state_out[%0d]", i), 128'(st_out_w[2]), KV_OUT);
      chk($sformatf("bp_in_ready[%0d]", i), 128'(in_ready_w[2]), 128'(0));
    end
    @(negedge clk);
    in_valid[2]  = 1'b0;
    out_ready[2] = 1'b1;
    @(posedge clk); #1;
    out_ready[2] = 1'b0;
    chk("bp_release_in_ready", 128'(in_ready_w[2]), 128'(1));
    chk("bp_release_out_valid", 128'(out_valid_w[2]), 128'(0));
    chk("bp_release_busy", 128'(busy_w[2]), 128'(0));
    repeat (3) @(posedge clk);
    #1;
    chk("bp_stray_ignored", 128'(st_out_w[2]), KV_OUT);
    chk("bp_stray_no_valid", 128'(out_valid_w[2]), 128'(0));

    // Asynchronous reset while holding a result in DONE.
    start_and_wait(2, KV_IN, lat);
    chk("done_before_rst", 128'(out_valid_w[2]), 128'(1));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_in_ready", 128'(in_ready_w[2]), 128'(1));
    chk("async_rst_out_valid", 128'(out_valid_w[2]), 128'(0));
    chk("async_rst_state_out", 128'(st_out_w[2]), ZERO);
    @(negedge clk);
    rst = 1'b0;

    // Reset during the second RUN cycle discards the block.
    @(negedge clk);
    st_in       = KV_IN;
    in_valid[2] = 1'b1;
    @(posedge clk); #1;
    in_valid[2] = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("midrst_busy", 128'(busy_w[2]), 128'(0));
    chk("midrst_in_ready", 128'(in_ready_w[2]), 128'(1));
    @(negedge clk);
    rst = 1'b0;
    ov_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid_w[2] === 1'b1) ov_seen++;
    end
    chk("midrst_no_out_valid", 128'(ov_seen), 128'(0));
    chk("midrst_state_out", 128'(st_out_w[2]), ZERO);
    run_block(2, ALL53, ALLED, 4);

    // LANES sweep with the known vector.
    for (int g = 0; g < 5; g++) begin
      run_block(g, KV_IN, KV_OUT, 16 >> g);
    end

`ifdef SUB_BYTES_INV_EN
    inv_r = 1'b1;
    run_block(2, ALL63, ZERO, 4);
    run_block(2, KV_OUT, KV_IN, 4);
    run_block(0, KV_OUT, KV_IN, 16);
    inv_r = 1'b0;
    run_block(2, KV_IN, KV_OUT, 4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
